// File: rtl/ev21g1_mem_arbiter_if.sv
// ev21g1_mem_arbiter_if: fetch, load/store and memory buses around the memory arbiter
interface ev21g1_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/ev21g1_mem_arbiter.sv
// ev21g1_mem_arbiter: single-port memory shared by fetch and load/store; define EV21G1_ARB_RR_EN for round-robin ties
module ev21g1_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic                 clk,
  input logic                 reset,
  ev21g1_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic              owner_ls, we_q, tie_ls, pick_ls, gnt_ok, gnt_any, done;
  logic              if_rvalid_q, ls_rvalid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, if_rdata_q, ls_rdata_q;

`ifdef EV21G1_ARB_RR_EN
  logic last_ls;
  assign tie_ls = !last_ls;
  // remember who won the last grant so the other side wins the next tie
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_ls <= 1'b0;
    else if (gnt_any) last_ls <= pick_ls;
`else
  assign tie_ls = 1'b1;
`endif

  assign gnt_ok  = reset && state == IDLE;
  assign pick_ls = bus.ls_req && (!bus.if_req || tie_ls);
  assign gnt_any = gnt_ok && (bus.if_req || bus.ls_req);
  assign done    = state == WAIT && cnt == 4'd0;

  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;

  // next state: IDLE -> ISSUE -> WAIT -> IDLE
  always_comb begin
    state_nx = state == IDLE  ? (gnt_any ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               done           ? IDLE : WAIT;
  end

  // outputs decoded from state; grants are combinational in IDLE
  always_comb begin
    bus.busy   = state != IDLE;
    bus.mem_en = state == ISSUE;
    bus.mem_we = state == ISSUE && we_q;
    bus.ls_gnt = gnt_ok && pick_ls;
    bus.if_gnt = gnt_ok && bus.if_req && !pick_ls;
  end

  // transaction latch, latency counter and per-requester return registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      owner_ls    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt         <= 4'd0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      if (gnt_any) begin
        owner_ls <= pick_ls;
        we_q     <= pick_ls && bus.ls_we;
        addr_q   <= pick_ls ? bus.ls_addr : bus.if_addr;
        if (pick_ls) wdata_q <= bus.ls_wdata;
      end
      cnt         <= state == ISSUE ? 4'(MEM_LAT - 1) : (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
      if_rvalid_q <= done && !owner_ls;
      ls_rvalid_q <= done && owner_ls;
      if (done && !owner_ls) if_rdata_q <= bus.mem_rdata;
      if (done && owner_ls && !we_q) ls_rdata_q <= bus.mem_rdata;
    end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
endmodule
